// File: rtl/ddr_frame_reader_if.sv
// ddr_frame_reader_if: AXI4 read address and read data channels.
// master modport faces the frame reader, slave modport faces memory.
interface ddr_frame_reader_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 4
);

  logic [AXI_ID_W-1:0]   m_axi_arid;
  logic [AXI_ADDR_W-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  logic [AXI_ID_W-1:0]   m_axi_rid;
  logic [AXI_DATA_W-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    output m_axi_arid,
    output m_axi_araddr,
    output m_axi_arlen,
    output m_axi_arsize,
    output m_axi_arburst,
    output m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid,
    input  m_axi_rdata,
    input  m_axi_rresp,
    input  m_axi_rlast,
    input  m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_arid,
    input  m_axi_araddr,
    input  m_axi_arlen,
    input  m_axi_arsize,
    input  m_axi_arburst,
    input  m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid,
    output m_axi_rdata,
    output m_axi_rresp,
    output m_axi_rlast,
    output m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/ddr_frame_reader.sv
// ddr_frame_reader: AXI4 burst reader feeding a FWFT FIFO and pixel stream.
// Optional stats outputs enabled by DDR_FRAME_READER_STATS_EN.
module ddr_frame_reader #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 4,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [AXI_ADDR_W-1:0] base_addr_i,
  input  logic [31:0]           frame_words_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  ddr_frame_reader_if.master    m_axi,
  output logic [AXI_DATA_W-1:0] pix_data_o,
  output logic                  pix_valid_o,
  input  logic                  pix_ready_i,
  output logic                  pix_sof_o
`ifdef DDR_FRAME_READER_STATS_EN
  ,
  output logic [15:0]           underrun_cnt_o,
  output logic [15:0]           frame_cnt_o
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int BYTES = AXI_DATA_W / 8;
  localparam int OFFS  = $clog2(BURST_LEN * BYTES);

  localparam logic [AXI_ADDR_W-1:0] BURST_BYTES =
    AXI_ADDR_W'(BURST_LEN * BYTES);
  localparam logic [AXI_ADDR_W-1:0] ALIGN_MASK =
    ~AXI_ADDR_W'((64'd1 << OFFS) - 64'd1);
  localparam logic [CW-1:0] SPACE_LIM =
    CW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [31:0] BURST_WORDS = 32'(BURST_LEN);
  localparam logic [2:0]  SIZE_CODE   = 3'($clog2(BYTES));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DRAIN
  } state_t;

  state_t                state_q;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [31:0]           words_left_q;
  logic [7:0]            beat_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  sof_q;

  logic [AXI_DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [CW-1:0]         wr_q;
  logic [CW-1:0]         rd_q;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_d;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  beat_bad;

  assign empty   = (wr_q == rd_q);
  assign count   = wr_q - rd_q;
  assign push    = rready_q & m_axi.m_axi_rvalid;
  assign pop     = pix_valid_o & pix_ready_i;
  assign count_d = count + CW'(push) - CW'(pop);

  assign beat_bad = (m_axi.m_axi_rresp != 2'b00)
                  | (m_axi.m_axi_rlast != (beat_q == LAST_BEAT))
                  | (m_axi.m_axi_rid != {AXI_ID_W{1'b0}});

  assign m_axi.m_axi_arid    = '0;
  assign m_axi.m_axi_araddr  = addr_q;
  assign m_axi.m_axi_arlen   = LAST_BEAT;
  assign m_axi.m_axi_arsize  = SIZE_CODE;
  assign m_axi.m_axi_arburst = 2'b01;
  assign m_axi.m_axi_arvalid = arvalid_q;
  assign m_axi.m_axi_rready  = rready_q;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign pix_valid_o = ~empty;
  assign pix_sof_o   = sof_q & ~empty;
  assign pix_data_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];

  // Frame sequencing: AR issue with space reservation, beats, drain.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
      beat_q       <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      sof_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) sof_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            err_q <= 1'b0;
            if (frame_words_i == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q       <= base_addr_i & ALIGN_MASK;
              words_left_q <= frame_words_i;
              busy_q       <= 1'b1;
              sof_q        <= 1'b1;
              arvalid_q    <= (count <= SPACE_LIM);
              state_q      <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (arvalid_q && m_axi.m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= S_DATA;
          end else if (!arvalid_q) begin
            arvalid_q <= (count <= SPACE_LIM);
          end
        end
        S_DATA: begin
          if (push) begin
            if (beat_bad) err_q <= 1'b1;
            beat_q <= beat_q + 8'd1;
            if (beat_q == LAST_BEAT) begin
              rready_q     <= 1'b0;
              words_left_q <= words_left_q - BURST_WORDS;
              addr_q       <= addr_q + BURST_BYTES;
              state_q      <= (words_left_q != BURST_WORDS)
                            ? S_ADDR : S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (count_d == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers move independently so push+pop works at full/empty.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + CW'(1);
      if (pop)  rd_q <= rd_q + CW'(1);
    end
  end

  // FIFO storage; never read before written, so left without reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q[AW-1:0]] <= m_axi.m_axi_rdata;
  end

`ifdef DDR_FRAME_READER_STATS_EN
  logic [15:0] underrun_q;
  logic [15:0] frame_cnt_q;

  assign underrun_cnt_o = underrun_q;
  assign frame_cnt_o    = frame_cnt_q;

  // Starvation cycles (saturating) and completed frames (wrapping).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      underrun_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (busy_q && empty &&
          state_q != S_IDLE && state_q != S_DRAIN &&
          underrun_q != 16'hFFFF)
        underrun_q <= underrun_q + 16'd1;
      if (done_q) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_frame_reader.sv
// tb_ddr_frame_reader: AXI memory model plus pixel-stream scoreboard.
// One task per scenario, run in sequence from the main initial block.
module tb_ddr_frame_reader;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int BL = 16;
  localparam int FD = 64;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [31:0] words = '0;
  logic        busy, done, err;
  logic [31:0] pix_data;
  logic        pix_valid, pix_sof;
  logic        pix_ready = 1'b0;
`ifdef DDR_FRAME_READER_STATS_EN
  logic [15:0] underrun_cnt, frame_cnt;
`endif

  ddr_frame_reader_if #(
    .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW)
  ) axi ();

  ddr_frame_reader #(
    .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW),
    .BURST_LEN(BL), .FIFO_DEPTH(FD)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .base_addr_i   (base),
    .frame_words_i (words),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .m_axi         (axi),
    .pix_data_o    (pix_data),
    .pix_valid_o   (pix_valid),
    .pix_ready_i   (pix_ready),
    .pix_sof_o     (pix_sof)
`ifdef DDR_FRAME_READER_STATS_EN
    ,
    .underrun_cnt_o(underrun_cnt),
    .frame_cnt_o   (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  pix_t        exp_q[$];
  logic [31:0] ar_exp_q[$];

  int ar_cnt, beats_in, pix_cnt, done_cnt, sof_cnt;
  int r_beat, burst_idx, stall_left;
  int err_burst = -1;
  int err_beat  = -1;
  int pix_mode  = 1;
  bit r_active, r_pending, first_pending, chk_valid_next;
  bit prev_arv, pv_hold;
  logic [31:0] r_addr, prev_araddr, pv_data, ea;
  logic [31:0] first_pix, last_pix;
  logic        pv_sof;
  pix_t        e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a - 32'h1000) >> 2;
  endfunction

  // Memory slave, stream sink and bus monitor, all working at negedge.
  initial begin
    axi.m_axi_arready = 1'b0;
    axi.m_axi_rvalid  = 1'b0;
    axi.m_axi_rdata   = '0;
    axi.m_axi_rresp   = '0;
    axi.m_axi_rlast   = 1'b0;
    axi.m_axi_rid     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi.m_axi_arready = 1'b0;
        axi.m_axi_rvalid  = 1'b0;
        axi.m_axi_rlast   = 1'b0;
        axi.m_axi_rresp   = '0;
        r_active = 0; r_pending = 0; prev_arv = 0;
        pv_hold = 0; chk_valid_next = 0;
      end else begin
        if (chk_valid_next) begin
          chk_valid_next = 0;
          n_assert++;
          if (pix_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pix_latency: got valid=%b expected 1", pix_valid);
          end
        end
        if (r_pending) begin
          r_pending = 0; r_active = 1; r_beat = 0;
        end
        if (r_active) begin
          axi.m_axi_rvalid = 1'b1;
          axi.m_axi_rid    = '0;
          axi.m_axi_rdata  = mem_word(r_addr + 32'(4 * r_beat));
          axi.m_axi_rlast  = (r_beat == BL - 1);
          axi.m_axi_rresp  = (burst_idx == err_burst &&
                              r_beat == err_beat) ? 2'b10 : 2'b00;
          n_assert++;
          if (axi.m_axi_rready !== 1'b1) begin
            n_fail++;
            $display("FAIL rready: got %b expected 1", axi.m_axi_rready);
          end else begin
            if (first_pending) chk_valid_next = 1;
            exp_q.push_back('{data: axi.m_axi_rdata, sof: first_pending});
            first_pending = 0;
            beats_in++;
            r_beat++;
            if (r_beat == BL) begin
              r_active = 0;
              burst_idx++;
            end
          end
        end else begin
          axi.m_axi_rvalid = 1'b0;
          axi.m_axi_rlast  = 1'b0;
          axi.m_axi_rresp  = '0;
        end
        if (prev_arv) begin
          n_assert++;
          if (axi.m_axi_arvalid !== 1'b1 ||
              axi.m_axi_araddr !== prev_araddr) begin
            n_fail++;
            $display("FAIL ar_stable: got v=%b a=%h expected v=1 a=%h",
                     axi.m_axi_arvalid, axi.m_axi_araddr, prev_araddr);
          end
        end
        prev_arv = 0;
        if (axi.m_axi_arvalid === 1'b1) begin
          n_assert++;
          if (r_active || r_pending) begin
            n_fail++;
            $display("FAIL ar_outstanding: got arvalid=1 expected 0");
          end
          if (stall_left > 0) begin
            stall_left--;
            axi.m_axi_arready = 1'b0;
            prev_arv = 1;
            prev_araddr = axi.m_axi_araddr;
          end else begin
            axi.m_axi_arready = 1'b1;
            ar_cnt++;
            ea = (ar_exp_q.size() != 0) ? ar_exp_q.pop_front() : 32'hDEAD_BEEF;
            n_assert++;
            if (axi.m_axi_araddr !== ea) begin
              n_fail++;
              $display("FAIL ar_addr: got %h expected %h",
                       axi.m_axi_araddr, ea);
            end
            n_assert++;
            if (axi.m_axi_arlen !== 8'd15 || axi.m_axi_arsize !== 3'd2 ||
                axi.m_axi_arburst !== 2'd1 || axi.m_axi_arid !== '0) begin
              n_fail++;
              $display("FAIL ar_fields: got len=%0d size=%0d burst=%0d id=%0d expected 15 2 1 0",
                       axi.m_axi_arlen, axi.m_axi_arsize,
                       axi.m_axi_arburst, axi.m_axi_arid);
            end
            r_pending = 1;
            r_addr = axi.m_axi_araddr;
          end
        end else begin
          axi.m_axi_arready = 1'b0;
        end
        if (pv_hold) begin
          n_assert++;
          if (pix_valid !== 1'b1 || pix_data !== pv_data ||
              pix_sof !== pv_sof) begin
            n_fail++;
            $display("FAIL pix_hold: got v=%b d=%h s=%b expected 1 %h %b",
                     pix_valid, pix_data, pix_sof, pv_data, pv_sof);
          end
        end
        case (pix_mode)
          0:       pix_ready = 1'b0;
          1:       pix_ready = 1'b1;
          default: pix_ready = 1'($urandom_range(0, 1));
        endcase
        pv_hold = (pix_valid === 1'b1) && !pix_ready;
        pv_data = pix_data;
        pv_sof  = pix_sof;
        if (pix_valid === 1'b1 && pix_ready) begin
          n_assert++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pix_extra: got %h expected no word", pix_data);
          end else begin
            e = exp_q.pop_front();
            if (pix_data !== e.data || pix_sof !== e.sof) begin
              n_fail++;
              $display("FAIL pix_word: got d=%h s=%b expected d=%h s=%b",
                       pix_data, pix_sof, e.data, e.sof);
            end
          end
          pix_cnt++;
          if (pix_sof === 1'b1) sof_cnt++;
          if (pix_cnt == 1) first_pix = pix_data;
          last_pix = pix_data;
        end
        if (done === 1'b1) begin
          done_cnt++;
          n_assert++;
          if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_busy: got busy=%b expected 0", busy);
          end
        end
      end
    end
  end

  task automatic start_frame(input logic [31:0] b, input logic [31:0] w);
    logic [31:0] al;
    @(negedge clk);
    al = b & ~32'h3F;
    for (int k = 0; k < int'(w) / BL; k++)
      ar_exp_q.push_back(al + 32'(64 * k));
    ar_cnt = 0; pix_cnt = 0; done_cnt = 0; sof_cnt = 0;
    beats_in = 0; burst_idx = 0;
    first_pending = (w != 0);
    start = 1'b1; base = b; words = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    int c = 0;
    while (done_cnt == 0 && c < bound) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
    ok = (done_cnt != 0);
  endtask

  task automatic wait_beats(input int n, input int bound);
    int c = 0;
    while (beats_in < n && c < bound) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({busy, done, err, pix_valid, pix_sof} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {busy, done, err, pix_valid, pix_sof});
    end
    n_assert++;
    if (pix_data !== '0 || axi.m_axi_araddr !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got d=%h a=%h expected 0 0",
               pix_data, axi.m_axi_araddr);
    end
    n_assert++;
    if (axi.m_axi_arvalid !== 1'b0 || axi.m_axi_rready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_axi: got arv=%b rr=%b expected 0 0",
               axi.m_axi_arvalid, axi.m_axi_rready);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    pix_mode = 1;
    start_frame(32'h1000, 32);
    n_assert++;
    if (axi.m_axi_arvalid !== 1'b1 || axi.m_axi_araddr !== 32'h1000 ||
        busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_ar: got v=%b a=%h busy=%b expected 1 1000 1",
               axi.m_axi_arvalid, axi.m_axi_araddr, busy);
    end
    wait_done(2000, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no done expected done"); end
    n_assert++;
    if (ar_cnt != 2 || pix_cnt != 32 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL basic_counts: got ar=%0d pix=%0d done=%0d expected 2 32 1",
               ar_cnt, pix_cnt, done_cnt);
    end
    n_assert++;
    if (first_pix !== 32'd0 || last_pix !== 32'd31 || sof_cnt != 1) begin
      n_fail++;
      $display("FAIL basic_words: got first=%0d last=%0d sof=%0d expected 0 31 1",
               first_pix, last_pix, sof_cnt);
    end
    n_assert++;
    if (err !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_end: got err=%b busy=%b left=%0d expected 0 0 0",
               err, busy, exp_q.size());
    end
`ifdef DDR_FRAME_READER_STATS_EN
    n_assert++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL frame_cnt: got %0d expected 1", frame_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    bit ok;
    pix_mode = 0;
    start_frame(32'h1000, 128);
    repeat (200) @(negedge clk);
    n_assert++;
    if (ar_cnt != 4 || beats_in != 64) begin
      n_fail++;
      $display("FAIL bp_fill: got ar=%0d beats=%0d expected 4 64",
               ar_cnt, beats_in);
    end
    n_assert++;
    if (axi.m_axi_arvalid !== 1'b0 || pix_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: got arv=%b pv=%b expected 0 1",
               axi.m_axi_arvalid, pix_valid);
    end
    pix_mode = 1;
    wait_done(3000, ok);
    n_assert++;
    if (!ok || ar_cnt != 8 || pix_cnt != 128 || last_pix !== 32'd127) begin
      n_fail++;
      $display("FAIL bp_frame: got ok=%0d ar=%0d pix=%0d last=%0d expected 1 8 128 127",
               ok, ar_cnt, pix_cnt, last_pix);
    end
  endtask

  task automatic test_ar_stall();
    bit ok;
    pix_mode = 2;
    stall_left = 10;
    start_frame(32'h1000, 32);
    for (int i = 0; i < 10; i++) begin
      n_assert++;
      if (axi.m_axi_arvalid !== 1'b1 || axi.m_axi_araddr !== 32'h1000 ||
          ar_cnt != 0) begin
        n_fail++;
        $display("FAIL ar_stall: got v=%b a=%h n=%0d expected 1 1000 0",
                 axi.m_axi_arvalid, axi.m_axi_araddr, ar_cnt);
      end
      @(negedge clk);
    end
    wait_done(3000, ok);
    n_assert++;
    if (!ok || ar_cnt != 2 || pix_cnt != 32 || last_pix !== 32'd31) begin
      n_fail++;
      $display("FAIL stall_frame: got ok=%0d ar=%0d pix=%0d last=%0d expected 1 2 32 31",
               ok, ar_cnt, pix_cnt, last_pix);
    end
  endtask

  task automatic test_error();
    bit ok;
    pix_mode = 1;
    err_burst = 1;
    err_beat  = 5;
    start_frame(32'h1000, 32);
    wait_beats(BL + 6, 500);
    @(negedge clk);
    n_assert++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got %b expected 1", err);
    end
    wait_done(2000, ok);
    n_assert++;
    if (!ok || err !== 1'b1 || pix_cnt != 32) begin
      n_fail++;
      $display("FAIL err_frame: got ok=%0d err=%b pix=%0d expected 1 1 32",
               ok, err, pix_cnt);
    end
    err_burst = -1;
    start_frame(32'h1000, 32);
    n_assert++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b expected 0", err);
    end
    wait_done(2000, ok);
    n_assert++;
    if (!ok || err !== 1'b0 || pix_cnt != 32) begin
      n_fail++;
      $display("FAIL err_after: got ok=%0d err=%b pix=%0d expected 1 0 32",
               ok, err, pix_cnt);
    end
  endtask

  task automatic test_zero_and_ignored();
    bit ok;
    pix_mode = 1;
    start_frame(32'h1000, 0);
    n_assert++;
    if (done !== 1'b1 || busy !== 1'b0 || axi.m_axi_arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: got done=%b busy=%b arv=%b expected 1 0 0",
               done, busy, axi.m_axi_arvalid);
    end
    repeat (6) @(negedge clk);
    n_assert++;
    if (ar_cnt != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_quiet: got ar=%0d done=%0d expected 0 1",
               ar_cnt, done_cnt);
    end
    start_frame(32'h1000, 32);
    wait_beats(8, 500);
    @(negedge clk);
    start = 1'b1; base = 32'h8000; words = 32'd64;
    @(negedge clk);
    start = 1'b0;
    n_assert++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ignored_busy: got %b expected 1", busy);
    end
    wait_done(2000, ok);
    n_assert++;
    if (!ok || ar_cnt != 2 || pix_cnt != 32 || last_pix !== 32'd31 ||
        done_cnt != 1 || ar_exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ignored_frame: got ok=%0d ar=%0d pix=%0d last=%0d done=%0d expected 1 2 32 31 1",
               ok, ar_cnt, pix_cnt, last_pix, done_cnt);
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    pix_mode = 1;
    start_frame(32'hFFFF_FFD4, 32);
    n_assert++;
    if (axi.m_axi_araddr !== 32'hFFFF_FFC0) begin
      n_fail++;
      $display("FAIL wrap_align: got %h expected ffffffc0", axi.m_axi_araddr);
    end
    wait_done(2000, ok);
    n_assert++;
    if (!ok || ar_cnt != 2 || pix_cnt != 32 || err !== 1'b0 ||
        first_pix !== mem_word(32'hFFFF_FFC0) ||
        last_pix !== mem_word(32'h0000_003C)) begin
      n_fail++;
      $display("FAIL wrap_frame: got ok=%0d ar=%0d pix=%0d err=%b first=%h last=%h expected 1 2 32 0 %h %h",
               ok, ar_cnt, pix_cnt, err, first_pix, last_pix,
               mem_word(32'hFFFF_FFC0), mem_word(32'h0000_003C));
    end
  endtask

  task automatic test_midframe_reset();
    bit ok;
    int c = 0;
    pix_mode = 1;
    start_frame(32'h1000, 32);
    while (beats_in < BL + 4 && c < 500) begin
      @(negedge clk);
      c++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({busy, done, err, pix_valid, pix_sof} !== 5'b0 ||
        pix_data !== '0) begin
      n_fail++;
      $display("FAIL rst_ctrl: got %b d=%h expected 00000 0",
               {busy, done, err, pix_valid, pix_sof}, pix_data);
    end
    n_assert++;
    if (axi.m_axi_arvalid !== 1'b0 || axi.m_axi_rready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_axi: got arv=%b rr=%b expected 0 0",
               axi.m_axi_arvalid, axi.m_axi_rready);
    end
    repeat (3) @(negedge clk);
    exp_q.delete();
    ar_exp_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_frame(32'h1000, 32);
    wait_done(2000, ok);
    n_assert++;
    if (!ok || ar_cnt != 2 || pix_cnt != 32 || first_pix !== 32'd0 ||
        last_pix !== 32'd31 || sof_cnt != 1) begin
      n_fail++;
      $display("FAIL rst_frame: got ok=%0d ar=%0d pix=%0d first=%0d last=%0d sof=%0d expected 1 2 32 0 31 1",
               ok, ar_cnt, pix_cnt, first_pix, last_pix, sof_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ar_stall();
    test_error();
    test_zero_and_ignored();
    test_addr_wrap();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ddr_frame_reader.md
Name: ddr_frame_reader

Overview:
- AXI4 read-only master; consumes the frame image the DDR loader has written to memory.
- Fetches a frame as fixed-length INCR bursts from a base address into an internal FIFO.
- Emits words on a valid/ready pixel stream, with start-of-frame marking, toward the HDMI output path.
- Runs entirely in the memory/AXI clock domain; the CDC to the pixel clock sits downstream.

Parameters:
- AXI_ADDR_W, 32, AXI address width.
- AXI_DATA_W, 32, AXI data width and pixel word width.
- AXI_ID_W, 4, AXI ID width; ARID is driven as constant 0.
- BURST_LEN, 16, beats per burst; power of 2, 1..256.
- FIFO_DEPTH, 64, output FIFO depth in words; power of 2, at least 2*BURST_LEN.

Ports:
- clk_i in 1 — system/AXI clock.
- rst_n_i in 1 — asynchronous active-low reset.
- start_i in 1 — one-cycle frame start request.
- base_addr_i in AXI_ADDR_W — frame base byte address, sampled on accepted start.
- frame_words_i in 32 — frame length in words, sampled on accepted start; multiple of BURST_LEN.
- busy_o out 1 — high from accepted start until done.
- done_o out 1 — one-cycle pulse when the last word leaves the stream.
- err_o out 1 — sticky error flag; cleared by an accepted start.
- m_axi_arid out AXI_ID_W; m_axi_araddr out AXI_ADDR_W; m_axi_arlen out 8; m_axi_arsize out 3; m_axi_arburst out 2; m_axi_arvalid out 1; m_axi_arready in 1.
- m_axi_rid in AXI_ID_W; m_axi_rdata in AXI_DATA_W; m_axi_rresp in 2; m_axi_rlast in 1; m_axi_rvalid in 1; m_axi_rready out 1.
- pix_data_o out AXI_DATA_W; pix_valid_o out 1; pix_ready_i in 1 — pixel stream.
- pix_sof_o out 1 — high with the first word of each frame.

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; counters 0.
- Constant AXI fields: arlen = BURST_LEN-1; arsize = log2(AXI_DATA_W/8); arburst = 2'b01 (INCR).
- Address: base low log2(BURST_LEN*AXI_DATA_W/8) bits forced to 0, so bursts never cross 4 KB.
- IDLE:
  - start_i with frame_words_i == 0: done_o pulses next cycle; no AR is issued.
  - start_i with frame_words_i != 0: latch address and word count, set busy_o, clear err_o, arm SOF, go to ADDR.
- ADDR:
  - arvalid asserts only when FIFO free space minus in-flight reservation is at least BURST_LEN.
  - araddr is held stable while arvalid is high and not accepted.
  - On arvalid && arready: go to DATA; beat counter = 0.
- DATA:
  - m_axi_rready is 1 throughout, because space was reserved before the burst was issued.
  - Each rvalid beat is pushed into the FIFO.
  - err_o sets on any of: rresp != 0; rlast disagreeing with beat count == BURST_LEN-1; rid != 0.
  - The burst always ends on the beat counter, not on rlast.
  - At burst end: words_left -= BURST_LEN; address += BURST_LEN*AXI_DATA_W/8; go to ADDR if words_left != 0, else DRAIN.
  - Only one burst is outstanding at any time.
- DRAIN:
  - Wait for the FIFO to empty; done_o pulses the cycle after the last pix handshake.
  - busy_o falls in the same cycle; return to IDLE.
- Stream side:
  - FIFO is first-word-fall-through: pix_valid_o = !empty.
  - Pop on pix_valid_o && pix_ready_i.
  - A push and a pop in the same cycle are both honoured, including at full and at empty.
  - pix_data_o is held stable while valid && !ready.
  - pix_sof_o is high with the first word after each start and stays high until that word is accepted.
- start_i while busy_o is high is ignored; it never corrupts the latched parameters.
- Address wraps modulo 2^AXI_ADDR_W without any error indication.
- Reset mid-frame: all state, FIFO contents and outputs clear asynchronously. A burst still in flight on the bus is the interconnect's concern, and it is also reset by rst_n_i.
- Latency: first arvalid one cycle after start; first pix_valid_o one cycle after the first R beat.

Optional Feature:
- Macro: DDR_FRAME_READER_STATS_EN.
- Defined:
  - Adds output underrun_cnt_o, 16 bits, saturating: counts cycles with busy_o high, FIFO empty, and state not IDLE/DRAIN.
  - Adds output frame_cnt_o, 16 bits, wrapping: increments on every done_o.
  - Both outputs reset to 0.
- Undefined: neither port nor its logic exists; behaviour is otherwise identical.

Test Plan:
- Frame and stream basics: base 0x1000, frame_words 32, memory word i = i, slave always ready, pix_ready_i = 1.
  - Exactly 2 AR transactions, at 0x1000 and 0x1040, arlen = 15, arsize = 2, arburst = 1.
  - Words 0..31 appear in order; pix_sof_o is high only with word 0.
  - One done_o pulse; err_o = 0.
- Backpressure: pix_ready_i = 0 for 200 cycles, frame_words 128.
  - At most 4 bursts are issued (FIFO depth 64); no R beat is ever dropped; arvalid stays low until space frees.
  - After release, all 128 words arrive in order.
- AR stall: arready held low for 10 cycles.
  - arvalid and araddr stay stable throughout; the burst proceeds normally after the handshake.
- Error response: rresp = 2 on beat 5 of burst 1.
  - err_o sets and stays set; the frame still completes with 32 words.
  - The next start clears err_o.
- Zero-length frame and ignored start: start with frame_words 0.
  - done_o pulses next cycle; no arvalid is raised.
  - start_i pulsed mid-frame changes nothing.
- Mid-frame reset: rst_n_i asserted during burst 2.
  - All outputs read 0 immediately.
  - A subsequent start completes the full frame correctly.
